osd_wr_arbiter: RTL and testbench

Shares the single OSD text-RAM write port between two requesters: CPU writes from the NIOS II system (buffered in a small FIFO) and a hardware fill engine that clears or paints a contiguous address range. It sits between the `system_n64adv1` `vd_wr*` exports and the `OSDWrVector` consumer in the video pipeline, in the `CLK_25M` domain. Its main job is to let firmware launch a fast screen clear without losing CPU writes issued during the clear.

---
 rtl/osd_wr_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_osd_wr_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_wr_arbiter.sv
// osd_wr_arbiter: shares the OSD text-RAM write port between buffered CPU
// writes and a hardware fill engine, with round-robin arbitration.
//
// Ports:
//   CLK_25M, nSRST_25M          clock, async active-low reset
//   cpu_wr_en/wrctrl/wraddr/wrdata  CPU write strobe and payload (into FIFO)
//   cpu_full, cpu_ovf           FIFO full, sticky dropped-push flag
//   fill_start/base/len/ctrl/data   fill launch strobe and parameters
//   fill_busy, fill_done        fill in progress, one-cycle completion pulse
//   OSDWrVector, osd_wr_en      registered {ctrl,addr,data} and its valid
module osd_wr_arbiter #(
    parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
    input  logic        CLK_25M,
    input  logic        nSRST_25M,
    input  logic        cpu_wr_en,
    input  logic [1:0]  cpu_wrctrl,
    input  logic [9:0]  cpu_wraddr,
    input  logic [12:0] cpu_wrdata,
    output logic        cpu_full,
    output logic        cpu_ovf,
    input  logic        fill_start,
    input  logic [9:0]  fill_base,
    input  logic [10:0] fill_len,
    input  logic [1:0]  fill_ctrl,
    input  logic [12:0] fill_data,
    output logic        fill_busy,
    output logic        fill_done,
    output logic [24:0] OSDWrVector,
    output logic        osd_wr_en
);

    localparam int unsigned PW      = FIFO_DEPTH_LOG2;
    localparam int unsigned DEPTH   = 2 ** FIFO_DEPTH_LOG2;
    localparam int unsigned CW      = FIFO_DEPTH_LOG2 + 1;
    localparam int unsigned VW      = 25;
    localparam int unsigned LW      = 11;
    localparam int unsigned MAX_LEN = 1024;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic       GNT_FILL = 1'b0;
    localparam logic       GNT_CPU  = 1'b1;

    // FIFO state
    logic [VW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          ovf_q, ovf_d;

    // Fill engine state
    logic [0:0]    state_q, state_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [9:0]    addr_q, addr_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [1:0]    fctrl_q, fctrl_d;
    logic [12:0]   fdata_q, fdata_d;

    // Output / arbiter state
    logic [VW-1:0] vec_q, vec_d;
    logic          wr_en_q, wr_en_d;
    logic          last_grant_q, last_grant_d;

    logic          push, pop;
    logic          cpu_req, fill_req;
    logic          grant_cpu, grant_fill;
    logic [VW-1:0] head;
    logic [LW-1:0] len_clamped;

    // Round-robin grant: CPU wins a contention only if fill had the last grant
    always_comb begin
        cpu_req    = (count_q != CW'(0));
        fill_req   = (state_q == ST_RUN);
        grant_cpu  = cpu_req && (!fill_req || (last_grant_q == GNT_FILL));
        grant_fill = fill_req && !grant_cpu;
    end

    // FIFO next state; a push into a full FIFO is dropped even if a pop frees a slot
    always_comb begin
        push     = cpu_wr_en && !full_q;
        pop      = grant_cpu;
        head     = mem_q[rd_ptr_q];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        full_d = (count_d == CW'(DEPTH));
        ovf_d  = ovf_q || (cpu_wr_en && full_q);
    end

    // Fill engine FSM next state
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        addr_d      = addr_q;
        rem_d       = rem_q;
        fctrl_d     = fctrl_q;
        fdata_d     = fdata_q;
        len_clamped = (fill_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : fill_len;
        case (state_q)
            ST_IDLE: begin
                if (fill_start) begin
                    if (len_clamped == LW'(0)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        busy_d  = 1'b1;
                        addr_d  = fill_base;
                        rem_d   = len_clamped;
                        fctrl_d = fill_ctrl;
                        fdata_d = fill_data;
                    end
                end
            end
            ST_RUN: begin
                if (grant_fill) begin
                    addr_d = addr_q + 10'(1);
                    rem_d  = rem_q - LW'(1);
                    if (rem_q == LW'(1)) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Output mux; vector holds its last value when nothing is granted
    always_comb begin
        vec_d        = vec_q;
        wr_en_d      = 1'b0;
        last_grant_d = last_grant_q;
        if (grant_cpu) begin
            vec_d        = head;
            wr_en_d      = 1'b1;
            last_grant_d = GNT_CPU;
        end else if (grant_fill) begin
            vec_d        = {fctrl_q, addr_q, fdata_q};
            wr_en_d      = 1'b1;
            last_grant_d = GNT_FILL;
        end
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge CLK_25M) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cpu_wrctrl, cpu_wraddr, cpu_wrdata};
        end
    end

    // State registers
    always_ff @(posedge CLK_25M or negedge nSRST_25M) begin
        if (!nSRST_25M) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            ovf_q        <= 1'b0;
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            addr_q       <= '0;
            rem_q        <= '0;
            fctrl_q      <= '0;
            fdata_q      <= '0;
            vec_q        <= '0;
            wr_en_q      <= 1'b0;
            last_grant_q <= GNT_FILL;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            full_q       <= full_d;
            ovf_q        <= ovf_d;
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            fctrl_q      <= fctrl_d;
            fdata_q      <= fdata_d;
            vec_q        <= vec_d;
            wr_en_q      <= wr_en_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign cpu_full    = full_q;
    assign cpu_ovf     = ovf_q;
    assign fill_busy   = busy_q;
    assign fill_done   = done_q;
    assign OSDWrVector = vec_q;
    assign osd_wr_en   = wr_en_q;

endmodule

// File: tb/tb_osd_wr_arbiter.sv
// Directed testbench for osd_wr_arbiter.
module tb_osd_wr_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cpu_wr_en;
    logic [1:0]  cpu_wrctrl;
    logic [9:0]  cpu_wraddr;
    logic [12:0] cpu_wrdata;
    logic        cpu_full;
    logic        cpu_ovf;
    logic        fill_start;
    logic [9:0]  fill_base;
    logic [10:0] fill_len;
    logic [1:0]  fill_ctrl;
    logic [12:0] fill_data;
    logic        fill_busy;
    logic        fill_done;
    logic [24:0] vec;
    logic        wr_en;

    int nvec = 0;
    int nerr = 0;

    osd_wr_arbiter #(.FIFO_DEPTH_LOG2(2)) dut (
        .CLK_25M    (clk),
        .nSRST_25M  (rst_n),
        .cpu_wr_en  (cpu_wr_en),
        .cpu_wrctrl (cpu_wrctrl),
        .cpu_wraddr (cpu_wraddr),
        .cpu_wrdata (cpu_wrdata),
        .cpu_full   (cpu_full),
        .cpu_ovf    (cpu_ovf),
        .fill_start (fill_start),
        .fill_base  (fill_base),
        .fill_len   (fill_len),
        .fill_ctrl  (fill_ctrl),
        .fill_data  (fill_data),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .OSDWrVector(vec),
        .osd_wr_en  (wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [9:0] a, input logic [12:0] d);
        cpu_wr_en  = 1'b1;
        cpu_wrctrl = 2'b01;
        cpu_wraddr = a;
        cpu_wrdata = d;
    endtask

    task automatic start_fill(input logic [9:0] b, input logic [10:0] l,
                              input logic [1:0] c, input logic [12:0] d);
        fill_start = 1'b1;
        fill_base  = b;
        fill_len   = l;
        fill_ctrl  = c;
        fill_data  = d;
        tick();
        fill_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cpu_wr_en = 1'b0; cpu_wrctrl = '0; cpu_wraddr = '0; cpu_wrdata = '0;
        fill_start = 1'b0; fill_base = '0; fill_len = '0; fill_ctrl = '0; fill_data = '0;
        #23;
        nvec++;
        if ({vec, wr_en, cpu_full, cpu_ovf, fill_busy, fill_done} !== 30'h0) begin
            nerr++;
            $display("FAIL reset_state: got vec=%h en=%b full=%b ovf=%b busy=%b done=%b, want all 0",
                     vec, wr_en, cpu_full, cpu_ovf, fill_busy, fill_done);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [24:0] exp_v [3];
        exp_v[0] = {2'b01, 10'h010, 13'h0041};
        exp_v[1] = {2'b01, 10'h011, 13'h0042};
        exp_v[2] = {2'b01, 10'h012, 13'h0043};
        push(10'h010, 13'h0041); tick();
        nvec++;
        if (wr_en !== 1'b0) begin
            nerr++; $display("FAIL b2b_latency: en=%b want 0", wr_en);
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 0) push(10'h011, 13'h0042);
            else if (i == 1) push(10'h012, 13'h0043);
            else cpu_wr_en = 1'b0;
            tick();
            if (i < 3) begin
                nvec++;
                if (wr_en !== 1'b1 || vec !== exp_v[i]) begin
                    nerr++; $display("FAIL b2b_word%0d: en=%b vec=%h want en=1 vec=%h", i, wr_en, vec, exp_v[i]);
                end
            end else begin
                nvec++;
                if (wr_en !== 1'b0 || vec !== exp_v[2]) begin
                    nerr++; $display("FAIL b2b_hold: en=%b vec=%h want en=0 vec=%h", wr_en, vec, exp_v[2]);
                end
            end
        end
        nvec++;
        if (cpu_ovf !== 1'b0) begin
            nerr++; $display("FAIL b2b_ovf: ovf=%b want 0", cpu_ovf);
        end
    endtask

    task automatic test_fill_wrap();
        logic [9:0]  a;
        logic [24:0] e;
        start_fill(10'h3FE, 11'd4, 2'b10, 13'h0020);
        nvec++;
        if (fill_busy !== 1'b1 || wr_en !== 1'b0) begin
            nerr++; $display("FAIL wrap_start: busy=%b en=%b want busy=1 en=0", fill_busy, wr_en);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            a = 10'h3FE + 10'(i);
            e = {2'b10, a, 13'h0020};
            nvec++;
            if (wr_en !== 1'b1 || vec !== e || fill_done !== (i == 3) || fill_busy !== (i != 3)) begin
                nerr++;
                $display("FAIL wrap_word%0d: en=%b vec=%h done=%b busy=%b want en=1 vec=%h done=%b busy=%b",
                         i, wr_en, vec, fill_done, fill_busy, e, (i == 3), (i != 3));
            end
        end
        tick();
        nvec++;
        if (wr_en !== 1'b0 || fill_done !== 1'b0) begin
            nerr++; $display("FAIL wrap_after: en=%b done=%b want 0 0", wr_en, fill_done);
        end
    endtask

    // Fill of 1024 with 7 back-to-back pushes; grants alternate CPU-first
    task automatic test_contention();
        logic [24:0] e;
        int nfill;
        bit  seen_done;
        start_fill(10'h000, 11'd1024, 2'b11, 13'h1555);
        tick();
        nvec++;
        if (wr_en !== 1'b1 || vec !== {2'b11, 10'h000, 13'h1555}) begin
            nerr++; $display("FAIL cont_w0: en=%b vec=%h want en=1 vec=%h", wr_en, vec, {2'b11, 10'h000, 13'h1555});
        end
        for (int s = 1; s <= 14; s++) begin
            if (s <= 7) push(10'h100 + 10'(s - 1), 13'h0A00 + 13'(s - 1));
            else cpu_wr_en = 1'b0;
            tick();
            if (s % 2 == 1) e = {2'b11, 10'((s + 1) / 2), 13'h1555};
            else            e = {2'b01, 10'h100 + 10'(s / 2 - 1), 13'h0A00 + 13'(s / 2 - 1)};
            nvec++;
            if (wr_en !== 1'b1 || vec !== e) begin
                nerr++; $display("FAIL cont_step%0d: en=%b vec=%h want en=1 vec=%h", s, wr_en, vec, e);
            end
            if (s == 7) begin
                nvec++;
                if (cpu_full !== 1'b1) begin
                    nerr++; $display("FAIL cont_full: full=%b want 1", cpu_full);
                end
            end
        end
        cpu_wr_en = 1'b0;
        nfill = 8;
        seen_done = 0;
        for (int c = 0; c < 1100 && !seen_done; c++) begin
            tick();
            if (wr_en) begin
                e = {2'b11, 10'(nfill), 13'h1555};
                nvec++;
                if (vec !== e) begin
                    nerr++; $display("FAIL cont_fill%0d: vec=%h want %h", nfill, vec, e);
                end
                nfill++;
            end
            if (fill_done) seen_done = 1;
        end
        nvec++;
        if (!seen_done || nfill != 1024 || fill_busy !== 1'b0 || cpu_ovf !== 1'b0) begin
            nerr++;
            $display("FAIL cont_end: done_seen=%0d words=%0d busy=%b ovf=%b want 1 1024 0 0",
                     seen_done, nfill, fill_busy, cpu_ovf);
        end
    endtask

    // 9 back-to-back pushes during a fill: the 8th meets a full FIFO and is dropped
    task automatic test_overflow();
        logic [12:0] got [$];
        logic [12:0] exp_d;
        int nfill;
        start_fill(10'h200, 11'd20, 2'b10, 13'h0111);
        tick();
        nfill = 1;
        for (int c = 0; c < 50; c++) begin
            if (c < 9) push(10'h100 + 10'(c), 13'h0B00 + 13'(c));
            else cpu_wr_en = 1'b0;
            tick();
            if (wr_en) begin
                if (vec[22:13] >= 10'h200) begin
                    nvec++;
                    if (vec !== {2'b10, 10'h200 + 10'(nfill), 13'h0111}) begin
                        nerr++; $display("FAIL ovf_fill%0d: vec=%h want %h", nfill, vec,
                                         {2'b10, 10'h200 + 10'(nfill), 13'h0111});
                    end
                    nfill++;
                end else begin
                    got.push_back(vec[12:0]);
                end
            end
            if (c < 9) begin
                nvec++;
                if (cpu_ovf !== (c >= 7)) begin
                    nerr++; $display("FAIL ovf_flag_push%0d: ovf=%b want %b", c, cpu_ovf, (c >= 7));
                end
            end
        end
        nvec++;
        if (got.size() != 8 || nfill != 20 || cpu_ovf !== 1'b1) begin
            nerr++; $display("FAIL ovf_counts: cpu_words=%0d fill_words=%0d ovf=%b want 8 20 1",
                             got.size(), nfill, cpu_ovf);
        end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            exp_d = 13'h0B00 + 13'((i < 7) ? i : 8);
            nvec++;
            if (got[i] !== exp_d) begin
                nerr++; $display("FAIL ovf_cpu%0d: data=%h want %h", i, got[i], exp_d);
            end
        end
    endtask

    task automatic test_zero_and_clamp();
        int  cnt;
        bit  seen_done;
        start_fill(10'h055, 11'd0, 2'b01, 13'h0FFF);
        nvec++;
        if (fill_done !== 1'b1 || fill_busy !== 1'b0 || wr_en !== 1'b0) begin
            nerr++; $display("FAIL zero_pulse: done=%b busy=%b en=%b want 1 0 0", fill_done, fill_busy, wr_en);
        end
        tick();
        nvec++;
        if (fill_done !== 1'b0 || fill_busy !== 1'b0 || wr_en !== 1'b0) begin
            nerr++; $display("FAIL zero_after: done=%b busy=%b en=%b want 0 0 0", fill_done, fill_busy, wr_en);
        end
        start_fill(10'h000, 11'd2047, 2'b00, 13'h0007);
        cnt = 0;
        seen_done = 0;
        for (int c = 0; c < 1100 && !seen_done; c++) begin
            tick();
            if (wr_en) cnt++;
            if (fill_done) begin
                seen_done = 1;
                nvec++;
                if (wr_en !== 1'b1 || vec !== {2'b00, 10'h3FF, 13'h0007}) begin
                    nerr++; $display("FAIL clamp_last: en=%b vec=%h want en=1 vec=%h", wr_en, vec,
                                     {2'b00, 10'h3FF, 13'h0007});
                end
            end
        end
        nvec++;
        if (!seen_done || cnt != 1024) begin
            nerr++; $display("FAIL clamp_count: done_seen=%0d writes=%0d want 1 1024", seen_done, cnt);
        end
    endtask

    task automatic test_reset_midfill();
        start_fill(10'h000, 11'd1000, 2'b11, 13'h0AAA);
        for (int c = 0; c < 500; c++) tick();
        for (int c = 0; c < 3; c++) begin
            push(10'h123, 13'h0C00 + 13'(c));
            tick();
        end
        cpu_wr_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        nvec++;
        if ({vec, wr_en, cpu_full, cpu_ovf, fill_busy, fill_done} !== 30'h0) begin
            nerr++;
            $display("FAIL rst_async: vec=%h en=%b full=%b ovf=%b busy=%b done=%b want all 0",
                     vec, wr_en, cpu_full, cpu_ovf, fill_busy, fill_done);
        end
        #4 rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            nvec++;
            if (wr_en !== 1'b0 || fill_busy !== 1'b0) begin
                nerr++; $display("FAIL rst_quiet%0d: en=%b busy=%b want 0 0", c, wr_en, fill_busy);
            end
        end
        push(10'h2AB, 13'h1234);
        tick();
        cpu_wr_en = 1'b0;
        nvec++;
        if (wr_en !== 1'b0) begin
            nerr++; $display("FAIL rst_new_lat: en=%b want 0", wr_en);
        end
        tick();
        nvec++;
        if (wr_en !== 1'b1 || vec !== {2'b01, 10'h2AB, 13'h1234}) begin
            nerr++; $display("FAIL rst_new_word: en=%b vec=%h want en=1 vec=%h", wr_en, vec,
                             {2'b01, 10'h2AB, 13'h1234});
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_fill_wrap();
        test_contention();
        test_overflow();
        test_zero_and_clamp();
        test_reset_midfill();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
